// File: rtl/mult_seq_4x4_if.sv
// Bundle of the multiplier request/result signals and the adder-stage
// operand/return signals.
//   slave  : the multiplier controller (mult_seq_4x4)
//   master : the environment (requester plus the combinational adder)
// Signals:
//   start, a, b              request and operands
//   busy, done, product      status and result
//   add_a, add_b, add_cin    operands driven to the adder
//   add_sum, add_cout        combinational adder return
interface mult_seq_4x4_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     add_a;
    logic [WIDTH-1:0]     add_b;
    logic                 add_cin;
    logic [WIDTH-1:0]     add_sum;
    logic                 add_cout;

    modport slave (
        input  start, a, b, add_sum, add_cout,
        output busy, done, product, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, add_sum, add_cout,
        input  busy, done, product, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mult_seq_4x4.sv
// Sequential unsigned shift-and-add multiplier using an external
// combinational WIDTH-bit adder. One iteration per clock, WIDTH iterations,
// then a single-cycle DONE state: throughput is one result per WIDTH+2 cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation)
//   bus  : mult_seq_4x4_if.slave (start/a/b in, busy/done/product out,
//          add_a/add_b/add_cin to the adder, add_sum/add_cout back)
module mult_seq_4x4 #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    mult_seq_4x4_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   p_q, p_nxt, p_step;
    logic [WIDTH-1:0] mcand_q, mcand_nxt;
    logic [CW-1:0]   count_q, count_nxt;
    logic [PW-1:0]   product_q, product_nxt;
    logic            busy_q, done_q;

    // One iteration: when the multiplier LSB is set, the adder result
    // (carry included) replaces the high half before the right shift.
    always_comb begin
        if (p_q[0])
            p_step = {bus.add_cout, bus.add_sum, p_q[WIDTH-1:1]};
        else
            p_step = {1'b0, p_q[PW-1:1]};
    end

    always_comb begin
        state_nxt   = state;
        p_nxt       = p_q;
        mcand_nxt   = mcand_q;
        count_nxt   = count_q;
        product_nxt = product_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    mcand_nxt = bus.a;
                    p_nxt     = {{WIDTH{1'b0}}, bus.b};
                    count_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                p_nxt     = p_step;
                count_nxt = count_q + CW'(1);
                if (count_q == LAST) begin
                    product_nxt = p_step;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are flopped from the next state so they are clean register
    // outputs that line up exactly with the RUN/DONE states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p_q       <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            p_q       <= p_nxt;
            mcand_q   <= mcand_nxt;
            count_q   <= count_nxt;
            product_q <= product_nxt;
            busy_q    <= (state_nxt != IDLE);
            done_q    <= (state_nxt == DONE);
        end
    end

    // Adder operands come straight from registers: no path from start/a/b.
    assign bus.add_a   = p_q[PW-1:WIDTH];
    assign bus.add_b   = mcand_q;
    assign bus.add_cin = 1'b0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq_4x4.sv
module tb_mult_seq_4x4;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    mult_seq_4x4_if #(.WIDTH(4)) bus ();

    mult_seq_4x4 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural 4-bit adder stage feeding the multiplier.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                       + {4'b0, bus.add_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issues a single start pulse and watches 10 cycles after the accept
    // edge (n=1 is the cycle right after it).
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv,
                          output logic [7:0] prod, output int lat,
                          output int bcnt, output int dcnt,
                          output int aa_or, output int bad_op);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tbv;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0; bcnt = 0; dcnt = 0; aa_or = 0; bad_op = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dcnt++;
                if (lat == 0) lat = n;
            end
            aa_or = aa_or | int'(bus.add_a);
            if (bus.add_cin !== 1'b0) bad_op++;
            if (bus.busy && bus.add_b !== ta) bad_op++;
        end
        prod = bus.product;
    endtask

    initial begin
        logic [7:0] prod;
        int lat, bcnt, dcnt, aa_or, bad_op;
        int dn[2];
        logic [7:0] dp[2];
        int nd;

        vecs[0] = '{4'd15, 4'd15, 8'hE1};
        vecs[1] = '{4'd7,  4'd9,  8'h3F};
        vecs[2] = '{4'd0,  4'd13, 8'h00};
        vecs[3] = '{4'd12, 4'd0,  8'h00};
        vecs[4] = '{4'd5,  4'd6,  8'h1E};
        vecs[5] = '{4'd11, 4'd13, 8'h8F};
        vecs[6] = '{4'd1,  4'd1,  8'h01};
        vecs[7] = '{4'd15, 4'd1,  8'h0F};
        vecs[8] = '{4'd8,  4'd8,  8'h40};
        vecs[9] = '{4'd3,  4'd5,  8'h0F};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = 4'd9;
        bus.b = 4'd9;
        repeat (3) @(negedge clk);
        check("reset busy",    int'(bus.busy),    0);
        check("reset done",    int'(bus.done),    0);
        check("reset product", int'(bus.product), 0);
        check("reset add_a",   int'(bus.add_a),   0);
        check("reset add_b",   int'(bus.add_b),   0);
        check("reset add_cin", int'(bus.add_cin), 0);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, prod, lat, bcnt, dcnt, aa_or, bad_op);
            check($sformatf("vec%0d product", i), int'(prod), int'(vecs[i].exp));
            check($sformatf("vec%0d done latency", i), lat, 5);
            check($sformatf("vec%0d done count", i), dcnt, 1);
            check($sformatf("vec%0d busy cycles", i), bcnt, 5);
            check($sformatf("vec%0d adder operands", i), bad_op, 0);
            if (vecs[i].b == 4'd0)
                check($sformatf("vec%0d add_a idle", i), aa_or, 0);
        end

        // Back-to-back with start held high: 7*9 then 0*13
        nd = 0;
        dn[0] = 0; dn[1] = 0; dp[0] = '0; dp[1] = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd9;
        @(negedge clk);
        bus.a = 4'd0; bus.b = 4'd13;
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.done) begin
                if (nd < 2) begin
                    dn[nd] = n;
                    dp[nd] = bus.product;
                end
                nd++;
            end
            if (n == 6) begin
                check("b2b idle gap busy", int'(bus.busy), 0);
                check("b2b held product", int'(bus.product), 63);
            end
            if (n == 7) begin
                check("b2b reaccept busy", int'(bus.busy), 1);
                check("b2b product kept on accept", int'(bus.product), 63);
                bus.start = 1'b0;
            end
        end
        check("b2b done count", nd, 2);
        check("b2b first done cycle", dn[0], 5);
        check("b2b first product", int'(dp[0]), 63);
        check("b2b second done cycle", dn[1], 11);
        check("b2b second product", int'(dp[1]), 0);

        // start during RUN of 5*6 must be ignored
        nd = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd6;
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 2) begin
                bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
            end
            if (n == 4) bus.start = 1'b0;
            if (bus.done) nd++;
            if (n == 5) check("ignore start product", int'(bus.product), 30);
        end
        check("ignore start done count", nd, 1);
        check("ignore start final product", int'(bus.product), 30);

        // Reset during the second RUN cycle of 11*13
        nd = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd11; bus.b = 4'd13;
        @(negedge clk);
        bus.start = 1'b0;
        check("pre-abort busy", int'(bus.busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        check("abort product", int'(bus.product), 0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("abort no done", nd, 0);
        run_op(4'd11, 4'd13, prod, lat, bcnt, dcnt, aa_or, bad_op);
        check("after abort product", int'(prod), 143);
        check("after abort latency", lat, 5);

        // Exhaustive sweep against reference model
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), prod, lat, bcnt, dcnt, aa_or, bad_op);
                check($sformatf("sweep %0d*%0d product", i, j), int'(prod), i * j);
                check($sformatf("sweep %0d*%0d done width", i, j), dcnt, 1);
                check($sformatf("sweep %0d*%0d latency", i, j), lat, 5);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
